// File: rtl/alu_req_arbiter_pkg.sv
// Shared constants for the two-port ALU request arbiter: opcodes, FSM encoding
// and the NZV flag-write mask.
package alu_req_arbiter_pkg;

    localparam int ARB_DW  = 16;
    localparam int ARB_OPW = 4;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRA = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;
    localparam logic [3:0] OP_NOP = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Mask bits ordered {N, Z, V}
    localparam logic [2:0] FM_NONE = 3'b000;
    localparam logic [2:0] FM_Z    = 3'b010;
    localparam logic [2:0] FM_NZV  = 3'b111;

    function automatic logic [2:0] flag_mask(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB:                 return FM_NZV;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: return FM_Z;
            default:                        return FM_NONE;
        endcase
    endfunction

    // 1100..1111 bypass the ALU and always return zero
    function automatic logic is_non_alu(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request, ALU and response bundle of the arbiter. The arbiter uses the slave
// modport; requesters, ALU and flag consumers sit on the master side.
interface alu_req_arbiter_if #(
    parameter int DW  = 16,
    parameter int OPW = 4
);
    logic           req0_valid;
    logic           req0_ready;
    logic [OPW-1:0] req0_op;
    logic [DW-1:0]  req0_a;
    logic [DW-1:0]  req0_b;
    logic           req1_valid;
    logic           req1_ready;
    logic [OPW-1:0] req1_op;
    logic [DW-1:0]  req1_a;
    logic [DW-1:0]  req1_b;
    logic [DW-1:0]  alu_in1;
    logic [DW-1:0]  alu_in2;
    logic [OPW-1:0] alu_opcode;
    logic [DW-1:0]  alu_out;
    logic           resp0_valid;
    logic           resp0_ready;
    logic           resp1_valid;
    logic           resp1_ready;
    logic [DW-1:0]  resp_data;
    logic           flag_n;
    logic           flag_z;
    logic           flag_v;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output alu_in1, alu_in2, alu_opcode,
        input  alu_out,
        output resp0_valid, resp1_valid, resp_data,
        input  resp0_ready, resp1_ready,
        output flag_n, flag_z, flag_v
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  alu_in1, alu_in2, alu_opcode,
        output alu_out,
        input  resp0_valid, resp1_valid, resp_data,
        output resp0_ready, resp1_ready,
        input  flag_n, flag_z, flag_v
    );

endinterface

// File: rtl/alu_req_arbiter_flag_unit.sv
// Architectural N/Z/V registers: computes candidate flags from the issued op and
// the ALU result and writes only the bits the opcode's mask allows.
module alu_flag_unit
    import alu_req_arbiter_pkg::*;
#(
    parameter int DW  = ARB_DW,
    parameter int OPW = ARB_OPW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           upd_en,
    input  logic [OPW-1:0] op,
    input  logic           a_sign,
    input  logic           b_sign,
    input  logic [DW-1:0]  result,
    output logic           flag_n,
    output logic           flag_z,
    output logic           flag_v
);

    logic [2:0] mask;
    logic       n_new, z_new, v_new;
    logic       n_q, n_d, z_q, z_d, v_q, v_d;

    always_comb begin
        mask  = upd_en ? flag_mask(op) : FM_NONE;
        n_new = result[DW-1];
        z_new = (result == '0);
        // SUB overflows when operand signs differ, ADD when they match
        if (op == OP_SUB) v_new = (a_sign != b_sign) && (n_new != a_sign);
        else              v_new = (a_sign == b_sign) && (n_new != a_sign);
        n_d = mask[2] ? n_new : n_q;
        z_d = mask[1] ? z_new : z_q;
        v_d = mask[0] ? v_new : v_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            n_q <= n_d;
            z_q <= z_d;
            v_q <= v_d;
        end
    end

    assign flag_n = n_q;
    assign flag_z = z_q;
    assign flag_v = v_q;

endmodule

// File: rtl/alu_req_arbiter.sv
// Two-port arbiter in front of the shared ALU: IDLE -> EXEC -> RESP per op,
// back-to-back when a new request is granted on the response handshake.
// ALU_ARB_RR_EN selects round-robin on conflicts; default is fixed priority to port 0.
module alu_req_arbiter
    import alu_req_arbiter_pkg::*;
#(
    parameter int DW  = ARB_DW,
    parameter int OPW = ARB_OPW
) (
    input  logic             clk,
    input  logic             rst,
    alu_req_arbiter_if.slave bus
);

    logic [1:0]     state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [DW-1:0]  a_q, a_d, b_q, b_d;
    logic [DW-1:0]  resp_data_q, resp_data_d;
    logic           owner_q, owner_d;
    logic [1:0]     req_valid, req_ready;
    logic           any_req, resp_hs, grant_en, winner;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign any_req   = |req_valid;
    assign resp_hs   = (state_q == ST_RESP) && (owner_q ? bus.resp1_ready : bus.resp0_ready);
    // Requests are only looked at in IDLE or on the response handshake
    assign grant_en  = rst && any_req && ((state_q == ST_IDLE) || resp_hs);

`ifdef ALU_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        winner = req_valid[1];
        if (&req_valid) winner = ~last_grant_q;
        last_grant_d = grant_en ? winner : last_grant_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) last_grant_q <= 1'b1;
        else      last_grant_q <= last_grant_d;
    end
`else
    assign winner = ~req_valid[0];
`endif

    assign req_ready = grant_en ? (winner ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        owner_d     = owner_q;
        resp_data_d = resp_data_q;
        if (grant_en) begin
            owner_d = winner;
            op_d    = winner ? bus.req1_op : bus.req0_op;
            a_d     = winner ? bus.req1_a  : bus.req0_a;
            b_d     = winner ? bus.req1_b  : bus.req0_b;
        end
        case (state_q)
            ST_IDLE: if (grant_en) state_d = ST_EXEC;
            ST_EXEC: begin
                state_d     = ST_RESP;
                resp_data_d = is_non_alu(op_q) ? '0 : bus.alu_out;
            end
            ST_RESP: if (resp_hs) state_d = grant_en ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            owner_q     <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            owner_q     <= owner_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign bus.req0_ready  = req_ready[0];
    assign bus.req1_ready  = req_ready[1];
    assign bus.alu_in1     = a_q;
    assign bus.alu_in2     = b_q;
    assign bus.alu_opcode  = op_q;
    assign bus.resp0_valid = (state_q == ST_RESP) && !owner_q;
    assign bus.resp1_valid = (state_q == ST_RESP) && owner_q;
    assign bus.resp_data   = resp_data_q;

    alu_flag_unit #(.DW(DW), .OPW(OPW)) u_flags (
        .clk    (clk),
        .rst    (rst),
        .upd_en (state_q == ST_EXEC),
        .op     (op_q),
        .a_sign (a_q[DW-1]),
        .b_sign (b_q[DW-1]),
        .result (bus.alu_out),
        .flag_n (bus.flag_n),
        .flag_z (bus.flag_z),
        .flag_v (bus.flag_v)
    );

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a small behavioural ALU on the bus.
module tb_alu_req_arbiter;
    import alu_req_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    alu_req_arbiter_if #(.DW(16), .OPW(4)) bus ();

    alu_req_arbiter #(.DW(16), .OPW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Non-ALU opcodes return a recognisable junk value so forcing to zero is visible
    always_comb begin
        case (bus.alu_opcode)
            4'h0:    bus.alu_out = bus.alu_in1 + bus.alu_in2;
            4'h1:    bus.alu_out = bus.alu_in1 - bus.alu_in2;
            4'h2:    bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
            default: bus.alu_out = 16'hDEAD;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222;
        bus.req1_valid = 1'b1; bus.req1_op = OP_SUB; bus.req1_a = 16'h3333; bus.req1_b = 16'h4444;
        bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
        step(); step();
        @(negedge clk);
        n_chk++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req0_ready: got %b exp 0", bus.req0_ready); end
        n_chk++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req1_ready: got %b exp 0", bus.req1_ready); end
        n_chk++; if ({bus.resp0_valid, bus.resp1_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_resp_valid: got %b exp 00", {bus.resp0_valid, bus.resp1_valid}); end
        n_chk++; if (bus.resp_data !== 16'h0000) begin n_fail++; $display("FAIL rst_resp_data: got %h exp 0000", bus.resp_data); end
        n_chk++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b exp 000", {bus.flag_n, bus.flag_z, bus.flag_v}); end
        n_chk++; if ({bus.alu_in1, bus.alu_in2, bus.alu_opcode} !== 36'h0) begin n_fail++; $display("FAIL rst_issue: got %h exp 0", {bus.alu_in1, bus.alu_in2, bus.alu_opcode}); end
        step();
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    endtask

    task automatic test_conflict();
        bus.req0_valid = 1'b1; bus.req0_op = OP_SUB; bus.req0_a = 16'h0005; bus.req0_b = 16'h0005;
        bus.req1_valid = 1'b1; bus.req1_op = OP_XOR; bus.req1_a = 16'h00F0; bus.req1_b = 16'h00FF;
        @(negedge clk);
        n_chk++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_fail++; $display("FAIL conf_grant0: got %b exp 01", {bus.req1_ready, bus.req0_ready}); end
        step();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL conf_exec_no_grant: got %b exp 0", bus.req1_ready); end
        n_chk++; if ({bus.alu_in1, bus.alu_in2, bus.alu_opcode} !== {16'h0005, 16'h0005, OP_SUB}) begin n_fail++; $display("FAIL conf_alu_in: got %h exp 000500051", {bus.alu_in1, bus.alu_in2, bus.alu_opcode}); end
        step();
        bus.resp0_ready = 1'b1;
        @(negedge clk);
        n_chk++; if ({bus.resp1_valid, bus.resp0_valid} !== 2'b01) begin n_fail++; $display("FAIL conf_resp0_valid: got %b exp 01", {bus.resp1_valid, bus.resp0_valid}); end
        n_chk++; if (bus.resp_data !== 16'h0000) begin n_fail++; $display("FAIL conf_sub_data: got %h exp 0000", bus.resp_data); end
        n_chk++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b010) begin n_fail++; $display("FAIL conf_sub_flags: got %b exp 010", {bus.flag_n, bus.flag_z, bus.flag_v}); end
        n_chk++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin n_fail++; $display("FAIL conf_grant1_b2b: got %b exp 10", {bus.req1_ready, bus.req0_ready}); end
        step();
        bus.req1_valid = 1'b0; bus.resp0_ready = 1'b0;
        step();
        bus.resp1_ready = 1'b1;
        @(negedge clk);
        n_chk++; if ({bus.resp1_valid, bus.resp0_valid} !== 2'b10) begin n_fail++; $display("FAIL conf_resp1_valid: got %b exp 10", {bus.resp1_valid, bus.resp0_valid}); end
        n_chk++; if (bus.resp_data !== 16'h000F) begin n_fail++; $display("FAIL conf_xor_data: got %h exp 000f", bus.resp_data); end
        n_chk++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b000) begin n_fail++; $display("FAIL conf_xor_flags: got %b exp 000", {bus.flag_n, bus.flag_z, bus.flag_v}); end
        step();
        bus.resp1_ready = 1'b0;
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_seq;
        logic       own;
`ifdef ALU_ARB_RR_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b0000;
`endif
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 16'h0001; bus.req0_b = 16'h0001;
        bus.req1_valid = 1'b1; bus.req1_op = OP_ADD; bus.req1_a = 16'h0002; bus.req1_b = 16'h0002;
        bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
        @(negedge clk);
        own = exp_seq[0];
        n_chk++; if ({bus.req1_ready, bus.req0_ready} !== {own, ~own}) begin n_fail++; $display("FAIL arb_grant0: got %b exp %b", {bus.req1_ready, bus.req0_ready}, {own, ~own}); end
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 3) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
            step();
            @(negedge clk);
            own = exp_seq[k];
            n_chk++; if ({bus.resp1_valid, bus.resp0_valid} !== {own, ~own}) begin n_fail++; $display("FAIL arb_resp_owner[%0d]: got %b exp %b", k, {bus.resp1_valid, bus.resp0_valid}, {own, ~own}); end
            n_chk++; if (bus.resp_data !== (own ? 16'h0004 : 16'h0002)) begin n_fail++; $display("FAIL arb_resp_data[%0d]: got %h exp %h", k, bus.resp_data, own ? 16'h0004 : 16'h0002); end
            if (k < 3) begin
                own = exp_seq[k+1];
                n_chk++; if ({bus.req1_ready, bus.req0_ready} !== {own, ~own}) begin n_fail++; $display("FAIL arb_grant[%0d]: got %b exp %b", k + 1, {bus.req1_ready, bus.req0_ready}, {own, ~own}); end
            end else begin
                n_chk++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_fail++; $display("FAIL arb_no_grant: got %b exp 00", {bus.req1_ready, bus.req0_ready}); end
            end
        end
        step();
        bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
    endtask

    task automatic test_add();
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 16'h7FFF; bus.req0_b = 16'h0001;
        @(negedge clk);
        n_chk++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_fail++; $display("FAIL add_grant: got %b exp 01", {bus.req1_ready, bus.req0_ready}); end
        step();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.resp0_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid: got %b exp 0", bus.resp0_valid); end
        step();
        @(negedge clk);
        n_chk++; if (bus.resp0_valid !== 1'b1) begin n_fail++; $display("FAIL add_resp_valid: got %b exp 1", bus.resp0_valid); end
        n_chk++; if (bus.resp_data !== 16'h8000) begin n_fail++; $display("FAIL add_data: got %h exp 8000", bus.resp_data); end
        n_chk++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b101) begin n_fail++; $display("FAIL add_flags: got %b exp 101", {bus.flag_n, bus.flag_z, bus.flag_v}); end
        bus.resp0_ready = 1'b1;
        step();
        bus.resp0_ready = 1'b0;
    endtask

    task automatic test_non_alu();
        bus.req0_valid = 1'b1; bus.req0_op = OP_HLT; bus.req0_a = 16'h0005; bus.req0_b = 16'h0005;
        @(negedge clk);
        n_chk++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL hlt_grant: got %b exp 1", bus.req0_ready); end
        step();
        bus.req0_valid = 1'b0;
        step();
        @(negedge clk);
        n_chk++; if (bus.resp0_valid !== 1'b1) begin n_fail++; $display("FAIL hlt_resp_valid: got %b exp 1", bus.resp0_valid); end
        n_chk++; if (bus.resp_data !== 16'h0000) begin n_fail++; $display("FAIL hlt_data: got %h exp 0000", bus.resp_data); end
        n_chk++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b101) begin n_fail++; $display("FAIL hlt_flags_kept: got %b exp 101", {bus.flag_n, bus.flag_z, bus.flag_v}); end
        bus.resp0_ready = 1'b1;
        step();
        bus.resp0_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 16'h0001; bus.req0_b = 16'h0001;
        step();
        bus.req0_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if ({bus.resp1_valid, bus.resp0_valid} !== 2'b00) begin n_fail++; $display("FAIL rstmid_no_resp: got %b exp 00", {bus.resp1_valid, bus.resp0_valid}); end
        n_chk++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: got %b exp 000", {bus.flag_n, bus.flag_z, bus.flag_v}); end
        n_chk++; if (bus.alu_in1 !== 16'h0000) begin n_fail++; $display("FAIL rstmid_issue: got %h exp 0000", bus.alu_in1); end
        step();
        @(negedge clk);
        n_chk++; if ({bus.resp1_valid, bus.resp0_valid} !== 2'b00) begin n_fail++; $display("FAIL rstmid_still_idle: got %b exp 00", {bus.resp1_valid, bus.resp0_valid}); end
        step();
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 16'h7FFF; bus.req0_b = 16'h0001;
        bus.req1_valid = 1'b1; bus.req1_op = OP_NOP; bus.req1_a = 16'h0000; bus.req1_b = 16'h0000;
        @(negedge clk);
        n_chk++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_fail++; $display("FAIL rstmid_conf_grant: got %b exp 01", {bus.req1_ready, bus.req0_ready}); end
        step();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        step();
        @(negedge clk);
        n_chk++; if (bus.resp_data !== 16'h8000) begin n_fail++; $display("FAIL rstmid_add_data: got %h exp 8000", bus.resp_data); end
        bus.resp0_ready = 1'b1;
        step();
        bus.resp0_ready = 1'b0;
    endtask

    task automatic test_stall();
        bus.req1_valid = 1'b1; bus.req1_op = OP_XOR; bus.req1_a = 16'h1234; bus.req1_b = 16'h1234;
        @(negedge clk);
        n_chk++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin n_fail++; $display("FAIL stall_grant1: got %b exp 10", {bus.req1_ready, bus.req0_ready}); end
        step();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 16'h0003; bus.req0_b = 16'h0003;
        @(negedge clk);
        n_chk++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL stall_exec_ready: got %b exp 0", bus.req0_ready); end
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++; if (bus.resp1_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b exp 1", i, bus.resp1_valid); end
            n_chk++; if (bus.resp_data !== 16'h0000) begin n_fail++; $display("FAIL stall_data[%0d]: got %h exp 0000", i, bus.resp_data); end
            n_chk++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b exp 0", i, bus.req0_ready); end
            step();
        end
        @(negedge clk);
        n_chk++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b111) begin n_fail++; $display("FAIL stall_xor_flags: got %b exp 111", {bus.flag_n, bus.flag_z, bus.flag_v}); end
        bus.resp1_ready = 1'b1;
        #1;
        n_chk++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_grant: got %b exp 1", bus.req0_ready); end
        step();
        bus.resp1_ready = 1'b0; bus.req0_valid = 1'b0; bus.resp0_ready = 1'b1;
        step();
        @(negedge clk);
        n_chk++; if ({bus.resp1_valid, bus.resp0_valid} !== 2'b01) begin n_fail++; $display("FAIL stall_next_owner: got %b exp 01", {bus.resp1_valid, bus.resp0_valid}); end
        n_chk++; if (bus.resp_data !== 16'h0006) begin n_fail++; $display("FAIL stall_next_data: got %h exp 0006", bus.resp_data); end
        n_chk++; if ({bus.flag_n, bus.flag_z, bus.flag_v} !== 3'b000) begin n_fail++; $display("FAIL stall_next_flags: got %b exp 000", {bus.flag_n, bus.flag_z, bus.flag_v}); end
        step();
        bus.resp0_ready = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_conflict();
        test_arbitration();
        test_add();
        test_non_alu();
        test_reset_mid_op();
        test_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
